// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, ALU opcodes and flag bit positions
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 16;
  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    XOR    = 3'd2,
    RED    = 3'd3,
    SLL    = 3'd4,
    SRA    = 3'd5,
    ROR    = 3'd6,
    PADDSB = 3'd7
  } opcode_e;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
endpackage

// File: rtl/dff_reg.sv
// dff_reg: W-bit register with load enable and asynchronous active-high clear
module dff_reg
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/operand_reg_file.sv
// operand_reg_file: 16x16 register file (R0 = 0) plus Z/V/N flag register; define RF_BYPASS_EN for write-to-read bypass
module operand_reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_reg1,
  input  logic [3:0]        src_reg2,
  input  logic [3:0]        dst_reg,
  input  logic              write_reg,
  input  logic [DATA_W-1:0] dst_data,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  input  logic              flag_wr,
  input  logic [2:0]        flag_op,
  input  logic [2:0]        alu_flags,
  output logic [2:0]        flags
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [2:0] flag_d;
  assign regs[0] = '0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_r
    dff_reg #(.W(DATA_W)) u_r (
      .clk(clk),
      .rst(rst),
      .en (write_reg && dst_reg == 4'(i)),
      .d  (dst_data),
      .q  (regs[i])
    );
  end
`ifdef RF_BYPASS_EN
  always_comb begin
    src_data1 = src_reg1 == '0 ? '0 : write_reg && dst_reg == src_reg1 ? dst_data : regs[src_reg1];
    src_data2 = src_reg2 == '0 ? '0 : write_reg && dst_reg == src_reg2 ? dst_data : regs[src_reg2];
  end
`else
  assign src_data1 = regs[src_reg1];
  assign src_data2 = regs[src_reg2];
`endif
  // only ADD/SUB produce meaningful V and N; every ALU op updates Z
  always_comb begin
    flag_d = (flag_op == ADD || flag_op == SUB) ? alu_flags : flags;
    flag_d[FLAG_Z] = alu_flags[FLAG_Z];
  end
  dff_reg #(.W(3)) u_flags (
    .clk(clk),
    .rst(rst),
    .en (flag_wr),
    .d  (flag_d),
    .q  (flags)
  );
endmodule
